// File: rtl/rpc2_ctrl_pkg.sv
// Shared types, AXI constants and the test data pattern for the AXI burst tester.
package rpc2_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    // Beat idx of a burst: add first, then XOR with the aligned start address.
    function automatic logic [DATA_W-1:0] rpc2_pattern(
        input logic [DATA_W-1:0] seed,
        input logic [DATA_W-1:0] addr,
        input logic [LEN_W-1:0]  idx
    );
        return (seed + {22'd0, idx, 2'b00}) ^ addr;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_pat_gen.sv
// Beat counter and pattern generator shared by write generation and read checking.
module rpc2_ctrl_pat_gen
    import rpc2_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] pat_c,
    output logic [DATA_W-1:0] pat_nxt_c,
    output logic              last_c,
    output logic              nxt_last_c
);

    logic [LEN_W-1:0] idx_q;

    // Beat index: cleared on command accept, advanced on every data handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (adv) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    assign pat_c      = rpc2_pattern(seed, addr, idx_q);
    assign pat_nxt_c  = rpc2_pattern(seed, addr, idx_q + LEN_W'(1));
    assign last_c     = (idx_q == len);
    assign nxt_last_c = ((9'(idx_q) + 9'd1) == 9'(len));

endmodule

// File: rtl/rpc2_ctrl_axi_tester.sv
// AXI4 burst initiator: one INCR write of a pattern or one INCR read checked against it.
module rpc2_ctrl_axi_tester
    import rpc2_ctrl_pkg::*;
#(
    parameter int unsigned C_AXI_MEM_ID_WIDTH   = 4,
    parameter int unsigned C_AXI_MEM_ADDR_WIDTH = 32,
    parameter int unsigned C_TESTER_ID          = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_AXI_MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                      cmd_len,
    input  logic [31:0]                     cmd_seed,
    output logic                            done,
    output logic                            done_err,
    output logic [15:0]                     mism_cnt,
    output logic [C_AXI_MEM_ID_WIDTH-1:0]   AXIm_AWID,
    output logic [C_AXI_MEM_ADDR_WIDTH-1:0] AXIm_AWADDR,
    output logic [7:0]                      AXIm_AWLEN,
    output logic [2:0]                      AXIm_AWSIZE,
    output logic [1:0]                      AXIm_AWBURST,
    output logic                            AXIm_AWVALID,
    input  logic                            AXIm_AWREADY,
    output logic [31:0]                     AXIm_WDATA,
    output logic [3:0]                      AXIm_WSTRB,
    output logic [C_AXI_MEM_ID_WIDTH-1:0]   AXIm_WID,
    output logic                            AXIm_WLAST,
    output logic                            AXIm_WVALID,
    input  logic                            AXIm_WREADY,
    output logic                            AXIm_BREADY,
    input  logic [C_AXI_MEM_ID_WIDTH-1:0]   AXIm_BID,
    input  logic [1:0]                      AXIm_BRESP,
    input  logic                            AXIm_BVALID,
    output logic [C_AXI_MEM_ID_WIDTH-1:0]   AXIm_ARID,
    output logic [C_AXI_MEM_ADDR_WIDTH-1:0] AXIm_ARADDR,
    output logic [7:0]                      AXIm_ARLEN,
    output logic [2:0]                      AXIm_ARSIZE,
    output logic [1:0]                      AXIm_ARBURST,
    output logic                            AXIm_ARVALID,
    input  logic                            AXIm_ARREADY,
    output logic                            AXIm_RREADY,
    input  logic [C_AXI_MEM_ID_WIDTH-1:0]   AXIm_RID,
    input  logic [31:0]                     AXIm_RDATA,
    input  logic [1:0]                      AXIm_RRESP,
    input  logic                            AXIm_RLAST,
    input  logic                            AXIm_RVALID
);

    localparam int unsigned IW = C_AXI_MEM_ID_WIDTH;
    localparam int unsigned AW = C_AXI_MEM_ADDR_WIDTH;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] seed_q;
    logic [IW-1:0]     id_q;

    logic        accept_c, cross_c;
    logic [10:0] span_c;
    logic        aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic [DATA_W-1:0] pat_c, pat_nxt_c;
    logic        last_c, nxt_last_c;
    logic        cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, done_d;
    logic        unused_c;

    assign accept_c = (state_q == ST_IDLE) & cmd_valid & cmd_ready;
    assign span_c   = 11'(cmd_addr[11:2]) + 11'(cmd_len);
    assign cross_c  = (span_c > 11'd1023);

    assign aw_hs_c = AXIm_AWVALID & AXIm_AWREADY;
    assign w_hs_c  = AXIm_WVALID  & AXIm_WREADY;
    assign b_hs_c  = AXIm_BVALID  & AXIm_BREADY;
    assign ar_hs_c = AXIm_ARVALID & AXIm_ARREADY;
    assign r_hs_c  = AXIm_RVALID  & AXIm_RREADY;

    // IDs are ignored: only one transaction is ever outstanding.
    assign unused_c = ^{1'b0, AXIm_BID, AXIm_RID, cmd_addr[1:0]};

    assign AXIm_AWID    = id_q;
    assign AXIm_WID     = id_q;
    assign AXIm_ARID    = id_q;
    assign AXIm_AWADDR  = addr_q;
    assign AXIm_ARADDR  = addr_q;
    assign AXIm_AWLEN   = len_q;
    assign AXIm_ARLEN   = len_q;
    assign AXIm_AWSIZE  = AXI_SIZE_4B;
    assign AXIm_ARSIZE  = AXI_SIZE_4B;
    assign AXIm_AWBURST = AXI_BURST_INCR;
    assign AXIm_ARBURST = AXI_BURST_INCR;
    assign AXIm_WSTRB   = 4'hF;

    rpc2_ctrl_pat_gen u_pat_gen (
        .clk        (clk),
        .reset      (reset),
        .clr        (accept_c),
        .adv        (w_hs_c | r_hs_c),
        .seed       (seed_q),
        .addr       (32'(addr_q)),
        .len        (len_q),
        .pat_c      (pat_c),
        .pat_nxt_c  (pat_nxt_c),
        .last_c     (last_c),
        .nxt_last_c (nxt_last_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = cross_c ? ST_DONE : (cmd_write ? ST_AW : ST_AR);
            ST_AW:   if (aw_hs_c) state_d = ST_W;
            ST_W:    if (w_hs_c && AXIm_WLAST) state_d = ST_B;
            ST_B:    if (b_hs_c) state_d = ST_DONE;
            ST_AR:   if (ar_hs_c) state_d = ST_R;
            ST_R:    if (r_hs_c && last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state so they register with it.
    always_comb begin
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        done_d      = 1'b0;
        unique case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_AW:   awvalid_d   = 1'b1;
            ST_W:    wvalid_d    = 1'b1;
            ST_B:    bready_d    = 1'b1;
            ST_AR:   arvalid_d   = 1'b1;
            ST_R:    rready_d    = 1'b1;
            ST_DONE: done_d      = 1'b1;
            default: cmd_ready_d = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready    <= 1'b0;
            AXIm_AWVALID <= 1'b0;
            AXIm_WVALID  <= 1'b0;
            AXIm_BREADY  <= 1'b0;
            AXIm_ARVALID <= 1'b0;
            AXIm_RREADY  <= 1'b0;
            done         <= 1'b0;
        end else begin
            cmd_ready    <= cmd_ready_d;
            AXIm_AWVALID <= awvalid_d;
            AXIm_WVALID  <= wvalid_d;
            AXIm_BREADY  <= bready_d;
            AXIm_ARVALID <= arvalid_d;
            AXIm_RREADY  <= rready_d;
            done         <= done_d;
        end
    end

    // Command latch, write data/last, and completion status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            seed_q     <= '0;
            id_q       <= '0;
            AXIm_WDATA <= '0;
            AXIm_WLAST <= 1'b0;
            done_err   <= 1'b0;
            mism_cnt   <= '0;
        end else begin
            if (accept_c) begin
                addr_q   <= {cmd_addr[AW-1:2], 2'b00};
                len_q    <= cmd_len;
                seed_q   <= cmd_seed;
                id_q     <= IW'(C_TESTER_ID);
                done_err <= cross_c;
                mism_cnt <= '0;
            end
            if (aw_hs_c) begin
                AXIm_WDATA <= pat_c;
                AXIm_WLAST <= (len_q == '0);
            end
            if (w_hs_c) begin
                AXIm_WDATA <= pat_nxt_c;
                AXIm_WLAST <= nxt_last_c;
            end
            if (b_hs_c && (AXIm_BRESP != AXI_RESP_OKAY)) begin
                done_err <= 1'b1;
            end
            if (r_hs_c) begin
                if ((AXIm_RDATA != pat_c) && (mism_cnt != 16'hFFFF)) begin
                    mism_cnt <= mism_cnt + CNT_W'(1);
                end
                if ((AXIm_RRESP != AXI_RESP_OKAY) || (AXIm_RLAST != last_c)) begin
                    done_err <= 1'b1;
                end
            end
        end
    end

endmodule
